// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shader IDs, default index-to-program map and index wrap helpers
package shader_pkg;

  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] SHADER_TRIANGLE = 4'h6;
  localparam logic [SEL_W-1:0] SHADER_CHECKER  = 4'h3;
  localparam logic [SEL_W-1:0] SHADER_ROTATE   = 4'h7;
  localparam logic [SEL_W-1:0] SHADER_CIRCLES  = 4'h8;
  localparam logic [SEL_W-1:0] SHADER_SINE     = 4'h4;
  localparam logic [SEL_W-1:0] SHADER_RADIAL   = 4'h2;

  // Entry i lives in bits [i*SEL_W +: SEL_W]; entries 6 and 7 are unused by default.
  localparam logic [8*SEL_W-1:0] DEFAULT_SHADER_MAP = {
    4'h0, 4'h0, SHADER_RADIAL, SHADER_SINE,
    SHADER_CIRCLES, SHADER_ROTATE, SHADER_CHECKER, SHADER_TRIANGLE
  };

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_NEXT,
    STEP_PREV
  } step_e;

  function automatic logic [2:0] idx_next(input logic [2:0] idx, input logic [2:0] last);
    return (idx == last) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [2:0] idx_prev(input logic [2:0] idx, input logic [2:0] last);
    return (idx == 3'd0) ? last : idx - 3'd1;
  endfunction

endpackage

// File: rtl/shader_sequencer_if.sv
// rtl/shader_sequencer_if.sv - button/auto inputs and shader selection outputs of the sequencer
interface shader_sequencer_if #(
  parameter int SEL_W = shader_pkg::SEL_W
);
  logic             btn_next_n;
  logic             btn_prev_n;
  logic             auto_en;
  logic [2:0]       shader_idx;
  logic [SEL_W-1:0] shader_select;
  logic             switch_pulse;

  modport master (
    output btn_next_n, btn_prev_n, auto_en,
    input  shader_idx, shader_select, switch_pulse
  );

  modport slave (
    input  btn_next_n, btn_prev_n, auto_en,
    output shader_idx, shader_select, switch_pulse
  );
endinterface

// File: rtl/shader_sequencer_debouncer.sv
// rtl/shader_sequencer_debouncer.sv - button_debouncer: 2-flop sync, debounce, press event; SHADER_SEQ_HOLD_REPEAT_EN adds hold-repeat
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] count;
  logic          repeat_ev;

`ifdef SHADER_SEQ_HOLD_REPEAT_EN
  localparam int HW = $clog2(16 * DEBOUNCE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_FIRST  = HW'(16 * DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(8 * DEBOUNCE_CYCLES);

  logic [HW-1:0] hold_cnt;

  // Reloading to 8*D makes every later repeat arrive 8*D cycles after the previous one.
  always_ff @(posedge clk) begin
    if (!rst_n || stable) begin
      hold_cnt  <= '0;
      repeat_ev <= 1'b0;
    end else if (hold_cnt == HOLD_FIRST) begin
      hold_cnt  <= HOLD_RELOAD;
      repeat_ev <= 1'b1;
    end else begin
      hold_cnt  <= hold_cnt + 1'b1;
      repeat_ev <= 1'b0;
    end
  end
`else
  assign repeat_ev = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0    <= 1'b1;
      sync1    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      count    <= '0;
      press    <= 1'b0;
    end else begin
      sync0    <= btn_n;
      sync1    <= sync0;
      stable_d <= stable;
      press    <= (stable_d & ~stable) | repeat_ev;
      if (sync1 == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= sync1;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/shader_sequencer.sv
// rtl/shader_sequencer.sv - debounced next/prev stepping with auto-advance and shader map; SHADER_SEQ_HOLD_REPEAT_EN enables hold-repeat
module shader_sequencer
  import shader_pkg::*;
#(
  parameter int                    NUM_SHADERS     = 6,
  parameter int                    SEL_W           = shader_pkg::SEL_W,
  parameter logic [8*SEL_W-1:0]    SHADER_MAP      = DEFAULT_SHADER_MAP,
  parameter int                    DEBOUNCE_CYCLES = 500000,
  parameter int                    AUTO_CYCLES     = 125000000
) (
  input  logic               clk,
  input  logic               rst_n,
  shader_sequencer_if.slave  bus
);
  localparam logic [2:0] IDX_LAST = 3'(NUM_SHADERS - 1);
  localparam int TW = $clog2(AUTO_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_CYCLES - 1);

  logic             next_ev;
  logic             prev_ev;
  logic             manual_ev;
  logic             expire;
  step_e            step;
  logic [TW-1:0]    timer;
  logic [2:0]       idx;
  logic             idx_changed;
  logic [SEL_W-1:0] select_q;
  logic             pulse_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (bus.btn_next_n),
    .press (next_ev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (bus.btn_prev_n),
    .press (prev_ev)
  );

  assign manual_ev = next_ev | prev_ev;
  assign expire    = bus.auto_en && (timer == TIMER_LAST);

  // Simultaneous next+prev cancel out; a manual event always swallows a coincident expiry.
  always_comb begin
    step = STEP_NONE;
    if (next_ev && !prev_ev) begin
      step = STEP_NEXT;
    end else if (prev_ev && !next_ev) begin
      step = STEP_PREV;
    end else if (!manual_ev && expire) begin
      step = STEP_NEXT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= 3'd0;
      timer       <= '0;
      idx_changed <= 1'b0;
      select_q    <= SHADER_MAP[SEL_W-1:0];
      pulse_q     <= 1'b0;
    end else begin
      if (!bus.auto_en || manual_ev || expire) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      case (step)
        STEP_NEXT: idx <= idx_next(idx, IDX_LAST);
        STEP_PREV: idx <= idx_prev(idx, IDX_LAST);
        default:   idx <= idx;
      endcase
      idx_changed <= (step != STEP_NONE);
      select_q    <= SHADER_MAP[idx*SEL_W +: SEL_W];
      pulse_q     <= idx_changed;
    end
  end

  assign bus.shader_idx    = idx;
  assign bus.shader_select = select_q;
  assign bus.switch_pulse  = pulse_q;
endmodule

// File: tb/tb_shader_sequencer.sv
// tb/tb_shader_sequencer.sv - directed self-checking bench for shader_sequencer
module tb_shader_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycle;
  int   pulse_cnt;

  shader_sequencer_if #(.SEL_W(4)) bus ();

  shader_sequencer #(
    .NUM_SHADERS     (6),
    .DEBOUNCE_CYCLES (4),
    .AUTO_CYCLES     (50)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (bus.switch_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic nxt, input logic prv);
    bus.btn_next_n = ~nxt;
    bus.btn_prev_n = ~prv;
    step(12);
    bus.btn_next_n = 1'b1;
    bus.btn_prev_n = 1'b1;
    step(12);
  endtask

  task automatic wait_pulse(input string tag, input int limit, output int at);
    logic found;
    found = 1'b0;
    at = 0;
    for (int i = 0; i < limit && !found; i++) begin
      step(1);
      if (bus.switch_pulse === 1'b1) begin
        found = 1'b1;
        at = cycle;
      end
    end
    check(tag, found, 1);
  endtask

  logic [3:0] exp_seq [6] = '{4'h3, 4'h7, 4'h8, 4'h4, 4'h2, 4'h6};
  int p1, p2, p3, p4, p5, saved;

  initial begin
    checks = 0;
    errors = 0;
    cycle = 0;
    pulse_cnt = 0;
    rst_n = 1'b0;
    bus.btn_next_n = 1'b1;
    bus.btn_prev_n = 1'b1;
    bus.auto_en = 1'b0;
    step(3);
    check("rst_idx", bus.shader_idx, 0);
    check("rst_select", bus.shader_select, 4'h6);
    check("rst_pulse", bus.switch_pulse, 0);
    rst_n = 1'b1;
    step(1);

    // single next press: exact pin-to-select latency of 9 cycles
    bus.btn_next_n = 1'b0;
    step(8);
    check("lat_idx_first", bus.shader_idx, 1);
    check("lat_select_old", bus.shader_select, 4'h6);
    step(1);
    check("lat_select_new", bus.shader_select, 4'h3);
    check("lat_pulse_hi", bus.switch_pulse, 1);
    step(1);
    check("lat_pulse_lo", bus.switch_pulse, 0);
    step(10);
    bus.btn_next_n = 1'b1;
    step(12);
    check("hold_one_pulse", pulse_cnt, 1);

    // 3-cycle glitch is rejected
    bus.btn_next_n = 1'b0;
    step(3);
    bus.btn_next_n = 1'b1;
    step(15);
    check("glitch_idx", bus.shader_idx, 1);
    check("glitch_pulses", pulse_cnt, 1);
    check("glitch_count", u_dut.u_next.count, 0);

    // back to 0, then walk the full table with wrap
    press(1'b0, 1'b1);
    check("prev_to_zero", bus.shader_idx, 0);
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 1'b0);
      check($sformatf("seq%0d_select", i), bus.shader_select, exp_seq[i]);
    end
    check("wrap_idx", bus.shader_idx, 0);
    press(1'b0, 1'b1);
    check("prev_wrap_idx", bus.shader_idx, 5);
    check("prev_wrap_select", bus.shader_select, 4'h2);

    // both buttons together cancel
    saved = pulse_cnt;
    press(1'b1, 1'b1);
    check("both_idx", bus.shader_idx, 5);
    check("both_pulses", pulse_cnt, saved);

    // auto-advance every 50 cycles, then a manual press at timer=30 restarts the period
    bus.auto_en = 1'b1;
    wait_pulse("auto1_seen", 120, p1);
    check("auto1_idx", bus.shader_idx, 0);
    wait_pulse("auto2_seen", 120, p2);
    check("auto_period", p2 - p1, 50);
    check("auto2_idx", bus.shader_idx, 1);
    step(22);
    bus.btn_next_n = 1'b0;
    step(7);
    check("timer_at_press", u_dut.timer, 30);
    wait_pulse("manual_seen", 20, p3);
    bus.btn_next_n = 1'b1;
    check("manual_gap", p3 - p2, 31);
    check("manual_idx", bus.shader_idx, 2);
    check("timer_cleared", u_dut.timer, 1);
    wait_pulse("auto3_seen", 120, p4);
    check("auto_after_manual", p4 - p3, 50);
    check("auto3_idx", bus.shader_idx, 3);

    // reset mid-debounce at idx=3
    bus.auto_en = 1'b0;
    bus.btn_next_n = 1'b0;
    step(4);
    check("mid_count", u_dut.u_next.count, 2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("mid_rst_idx", bus.shader_idx, 0);
    check("mid_rst_select", bus.shader_select, 4'h6);
    check("mid_rst_count", u_dut.u_next.count, 0);
    step(2);
    check("restart_count0", u_dut.u_next.count, 0);
    step(1);
    check("restart_count1", u_dut.u_next.count, 1);
    wait_pulse("post_rst_seen", 20, p5);
    check("post_rst_idx", bus.shader_idx, 1);
    check("post_rst_select", bus.shader_select, 4'h3);
    bus.btn_next_n = 1'b1;
    step(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
